mod_seq_arbiter: RTL and testbench
==================================

// Module: mod_seq_arbiter
// PURPOSE
// Round-robin arbiter that shares one resource among N_REQ requesters.
// Slot IDs run 1..N_REQ and wrap N_REQ->1, matching the team's modulo-sequence counters.
// Sits between requesting units and the shared resource.
// Issues one registered, one-hot grant at a time, with a hold timeout and a fixed cool-down gap.
// PARAMETERS
// N_REQ     5   number of requesters; IDs 1..N_REQ, ID 0 = no grant
// ID_W      3   width of gnt_id; must satisfy 2**ID_W > N_REQ
// MAX_HOLD  8   maximum cycles one grant may be held before forced release (>=2)
// PORTS
// clk      in   1      rising-edge clock
// rst      in   1      asynchronous, active-high reset
// req      in   N_REQ  request vector; bit i-1 = requester ID i; level-held while resource wanted
// gnt      out  N_REQ  one-hot grant (registered); all-zero when no grant
// gnt_id   out  ID_W   ID of current grant holder 1..N_REQ; 0 when no grant
// busy     out  1      1 while in GRANT state
// timeout  out  1      one-cycle pulse on the cycle following a forced release
// BEHAVIOUR
// - Reset (async, immediate):
//   - state=IDLE, gnt=0, gnt_id=0, busy=0, timeout=0, hold_cnt=0.
//   - last_id=N_REQ, so the first search starts at ID 1.
// - FSM states: IDLE, GRANT, COOL.
// - IDLE:
//   - If req!=0 at an edge: pick the first requesting ID scanning last_id+1, +2, ... with wrap N_REQ->1.
//   - Same edge: gnt/gnt_id/busy set, hold_cnt=0, ->GRANT. Latency req->gnt = 1 clock.
//   - If req==0: stay in IDLE.
// - GRANT:
//   - Only req[gnt_id] is examined; other requests wait.
//   - req[gnt_id]==0 at edge: normal release. gnt=0, gnt_id=0, busy=0, last_id<=held ID, ->COOL.
//   - Else if hold_cnt==MAX_HOLD-1: forced release. Same updates as normal release, plus timeout=1 for one cycle.
//   - Else: hold_cnt++.
//   - A grant therefore lasts at most MAX_HOLD cycles.
// - Simultaneous drop of req and hold expiry at the same edge: treated as a normal release; timeout stays 0.
// - COOL:
//   - Exactly one cycle with gnt=0, then ->IDLE.
//   - Minimum gap between consecutive grants = 2 cycles (COOL + IDLE pick).
// - A timed-out requester still holding req stays eligible, but is now lowest priority (round-robin).
// - Invariants, checked by bench assertions:
//   - gnt is one-hot or zero.
//   - gnt==(1<<(gnt_id-1)) whenever gnt_id!=0.
//   - busy==(state==GRANT).
// - Widths:
//   - hold_cnt is $clog2(MAX_HOLD) bits and never wraps.
//   - last_id/gnt_id are ID_W bits and never take values > N_REQ.
// - Reset asserted mid-grant: outputs clear asynchronously; the first grant after release searches from ID 1.
// STRUCTURE
// - Package mod_seq_pkg:
//   - typedef enum {IDLE,GRANT,COOL} arb_state_t.
//   - function next_id(id,n) wrapping n->1.
//   - localparam NO_GRANT=0.
// - Sub-module rr_pick (combinational): inputs req and last_id; outputs found and pick_id (wrap-around priority scan).
// - Top level holds the FSM, hold counter and output registers.
// TESTING (N_REQ=5, MAX_HOLD=8)
// 1. Reset, then req=5'b00100 -> after next edge gnt=5'b00100, gnt_id=3, busy=1; drop req -> gnt=0 next edge.
// 2. req=5'b11111, each holder drops req 2 cycles after its grant -> grant order 1,2,3,4,5,1, with a 2-cycle gap between grants.
// 3. Last grant ID 5, then req=5'b10010 -> next grant ID 2 (wrap, ID 1 idle), then ID 5.
// 4. ID 4 holds req for 20 cycles -> gnt high exactly 8 cycles, timeout pulse 1 cycle, re-granted after COOL+IDLE.
// 5. Assert rst mid-grant of ID 3 -> gnt=0, gnt_id=0 without waiting for clk; after release, req=5'b11111 -> ID 1 granted.
// 6. Holder drops req on the same edge hold_cnt==7 -> release with timeout=0; next requester granted per round-robin.

Source files
------------

// File: rtl/mod_seq_pkg.sv
// Shared types and helpers for the round-robin sequence arbiter.
// IDs follow the modulo-sequence convention 1..n with wrap n->1; 0 means "none".
package mod_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        COOL  = 2'd2
    } arb_state_t;

    localparam int NO_GRANT = 0;
    localparam int SEQ_W    = 8;

    // Successor in the 1..n sequence; anything at or beyond n wraps back to 1.
    function automatic logic [SEQ_W-1:0] next_id(input logic [SEQ_W-1:0] id,
                                                 input logic [SEQ_W-1:0] n);
        return (id >= n) ? SEQ_W'(1) : id + SEQ_W'(1);
    endfunction

endpackage

// File: rtl/mod_seq_arbiter_rr_pick.sv
// Combinational wrap-around priority scan: first requesting ID after last_id.
// Candidate j (0-based) is the ID j+1 steps after last_id in the 1..N_REQ sequence.
module rr_pick
    import mod_seq_pkg::*;
#(
    parameter int N_REQ = 5,
    parameter int ID_W  = 3
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last_id,
    output logic             found,
    output logic [ID_W-1:0]  pick_id
);

    logic [2*N_REQ-1:0] doubled;
    logic [N_REQ-1:0]   rotated;
    logic [ID_W-1:0]    cand_id [N_REQ];

    // rotated[j] is the request bit of requester cand_id[j].
    assign doubled = {req, req};
    assign rotated = doubled[last_id +: N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_cand
            if (gi == 0) begin : g_first
                assign cand_id[gi] = ID_W'(next_id(SEQ_W'(last_id), SEQ_W'(N_REQ)));
            end else begin : g_rest
                assign cand_id[gi] = ID_W'(next_id(SEQ_W'(cand_id[gi-1]), SEQ_W'(N_REQ)));
            end
        end
    endgenerate

    // Scan from the far end so the nearest requesting candidate wins.
    always_comb begin
        found   = 1'b0;
        pick_id = ID_W'(NO_GRANT);
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (rotated[j]) begin
                found   = 1'b1;
                pick_id = cand_id[j];
            end
        end
    end

endmodule

// File: rtl/mod_seq_arbiter.sv
// Round-robin arbiter with registered one-hot grant, hold timeout and a
// one-cycle cool-down between grants.
module mod_seq_arbiter
    import mod_seq_pkg::*;
#(
    parameter int N_REQ    = 5,
    parameter int ID_W     = 3,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             busy,
    output logic             timeout
);

    localparam int HCW = $clog2(MAX_HOLD);

    arb_state_t        state_reg, state_next;
    logic [HCW-1:0]    hold_cnt_reg, hold_cnt_next;
    logic [ID_W-1:0]   last_id_reg, last_id_next;
    logic [ID_W-1:0]   gnt_id_reg, gnt_id_next;
    logic [N_REQ-1:0]  gnt_reg, gnt_next;
    logic              busy_reg, busy_next;
    logic              timeout_reg, timeout_next;
    logic              found;
    logic [ID_W-1:0]   pick_id;
    logic              holder_req;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req     (req),
        .last_id (last_id_reg),
        .found   (found),
        .pick_id (pick_id)
    );

    // Only the current holder's request line matters while granted.
    assign holder_req = |(req & gnt_reg);

    always_comb begin
        state_next    = state_reg;
        hold_cnt_next = hold_cnt_reg;
        last_id_next  = last_id_reg;
        gnt_id_next   = gnt_id_reg;
        timeout_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (found) begin
                    gnt_id_next   = pick_id;
                    hold_cnt_next = '0;
                    state_next    = GRANT;
                end
            end
            GRANT: begin
                if (!holder_req || hold_cnt_reg == HCW'(MAX_HOLD - 1)) begin
                    // A dropped request takes precedence, so timeout only flags a true expiry.
                    timeout_next  = holder_req;
                    last_id_next  = gnt_id_reg;
                    gnt_id_next   = ID_W'(NO_GRANT);
                    hold_cnt_next = '0;
                    state_next    = COOL;
                end else begin
                    hold_cnt_next = hold_cnt_reg + HCW'(1);
                end
            end
            COOL: begin
                state_next = IDLE;
            end
            default: begin
                gnt_id_next = ID_W'(NO_GRANT);
                state_next  = IDLE;
            end
        endcase
        busy_next = (state_next == GRANT);
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_gnt_dec
            assign gnt_next[gi] = (gnt_id_next == ID_W'(gi + 1));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            hold_cnt_reg <= '0;
            last_id_reg  <= ID_W'(N_REQ);
            gnt_id_reg   <= ID_W'(NO_GRANT);
            gnt_reg      <= '0;
            busy_reg     <= 1'b0;
            timeout_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            hold_cnt_reg <= hold_cnt_next;
            last_id_reg  <= last_id_next;
            gnt_id_reg   <= gnt_id_next;
            gnt_reg      <= gnt_next;
            busy_reg     <= busy_next;
            timeout_reg  <= timeout_next;
        end
    end

    assign gnt     = gnt_reg;
    assign gnt_id  = gnt_id_reg;
    assign busy    = busy_reg;
    assign timeout = timeout_reg;

endmodule

// File: tb/tb_mod_seq_arbiter.sv
// Bench for mod_seq_arbiter: directed scenarios plus randomized requests,
// with a per-cycle comparison against a grant-history reference model.
module tb_mod_seq_arbiter;

    localparam int N_REQ    = 5;
    localparam int ID_W     = 3;
    localparam int MAX_HOLD = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N_REQ-1:0] req = '0;
    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_id;
    logic             busy;
    logic             timeout;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    mod_seq_arbiter #(
        .N_REQ    (N_REQ),
        .ID_W     (ID_W),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: who holds the resource, for how many visible cycles,
    // whether the mandatory idle cycle after a release is still pending.
    int m_holder, m_held, m_last;
    bit m_cool, m_to;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_holder = 0; m_held = 0; m_last = N_REQ; m_cool = 0; m_to = 0;
        end else begin
            m_to = 0;
            if (m_holder != 0) begin
                if (!req[m_holder-1] || m_held == MAX_HOLD) begin
                    m_to     = req[m_holder-1];
                    m_last   = m_holder;
                    m_holder = 0;
                    m_cool   = 1;
                end else begin
                    m_held++;
                end
            end else if (m_cool) begin
                m_cool = 0;
            end else begin
                for (int k = 1; k <= N_REQ; k++) begin
                    int id;
                    id = ((m_last + k - 1) % N_REQ) + 1;
                    if (m_holder == 0 && req[id-1]) begin
                        m_holder = id;
                        m_held   = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [N_REQ-1:0] exp_gnt;
        exp_gnt = (m_holder != 0) ? N_REQ'(1 << (m_holder - 1)) : '0;
        check("model_gnt", 32'(gnt), 32'(exp_gnt));
        check("model_gnt_id", 32'(gnt_id), 32'(m_holder));
        check("model_busy", 32'(busy), 32'(m_holder != 0));
        check("model_timeout", 32'(timeout), 32'(m_to));
        check("inv_onehot0", 32'($onehot0(gnt)), 32'd1);
        check("inv_id_range", 32'(gnt_id <= ID_W'(N_REQ)), 32'd1);
        if (gnt_id != 0)
            check("inv_gnt_vs_id", 32'(gnt), 32'(1 << (gnt_id - 1)));
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_grant(output int id);
        id = 0;
        for (int i = 0; i < 20; i++) begin
            if (gnt_id != 0) begin
                id = int'(gnt_id);
                return;
            end
            tick(1);
        end
        checks++;
        failures++;
        $display("FAIL wait_grant t=%0t actual=no_grant expected=grant_within_20_cycles", $time);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
    endtask

    initial begin
        int id;
        int stamps[6];
        int exp_order[6] = '{1, 2, 3, 4, 5, 1};
        int hi_cnt, to_cnt;

        // 1: reset state, single request, release
        tick(2);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_gnt_id", 32'(gnt_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        rst = 1'b0;
        tick(1);
        req = 5'b00100;
        tick(1);
        check("t1_gnt", 32'(gnt), 32'b00100);
        check("t1_gnt_id", 32'(gnt_id), 32'd3);
        check("t1_busy", 32'(busy), 32'd1);
        req = '0;
        tick(1);
        check("t1_release", 32'(gnt), 32'd0);
        tick(2);

        // 2: all request, each holds two cycles
        pulse_reset();
        req = 5'b11111;
        for (int g = 0; g < 6; g++) begin
            wait_grant(id);
            stamps[g] = cyc;
            check($sformatf("t2_order%0d", g), 32'(id), 32'(exp_order[g]));
            if (g > 0) check($sformatf("t2_spacing%0d", g), 32'(stamps[g] - stamps[g-1]), 32'd4);
            tick(1);
            if (id != 0) req[id-1] = 1'b0;
            tick(1);
            if (g < 5 && id != 0) req[id-1] = 1'b1;
        end
        req = '0;
        tick(3);

        // 3: wrap from ID 5 skips idle ID 1
        pulse_reset();
        req = 5'b10000;
        wait_grant(id);
        check("t3_first", 32'(id), 32'd5);
        req = '0;
        tick(1);
        req = 5'b10010;
        wait_grant(id);
        check("t3_wrap", 32'(id), 32'd2);
        req = 5'b10000;
        tick(1);
        wait_grant(id);
        check("t3_next", 32'(id), 32'd5);
        req = '0;
        tick(3);

        // 4: hold timeout
        req = 5'b01000;
        hi_cnt = 0;
        to_cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            if (i <= 10) begin
                if (gnt == 5'b01000) hi_cnt++;
                if (timeout) to_cnt++;
            end
            if (i == 11) check("t4_regrant", 32'(gnt_id), 32'd4);
        end
        check("t4_hold_cycles", 32'(hi_cnt), 32'd8);
        check("t4_timeout_pulses", 32'(to_cnt), 32'd1);
        req = '0;
        tick(3);

        // 5: asynchronous reset in the middle of a grant
        req = 5'b00100;
        wait_grant(id);
        check("t5_grant", 32'(id), 32'd3);
        tick(1);
        rst = 1'b1;
        req = 5'b11111;
        #1;
        check("t5_async_gnt", 32'(gnt), 32'd0);
        check("t5_async_id", 32'(gnt_id), 32'd0);
        check("t5_async_busy", 32'(busy), 32'd0);
        #3;
        rst = 1'b0;
        tick(1);
        check("t5_after_rst", 32'(gnt_id), 32'd1);
        req = '0;
        tick(3);

        // 6: request drops on the same edge the hold expires
        req = 5'b00110;
        wait_grant(id);
        check("t6_grant", 32'(id), 32'd2);
        tick(MAX_HOLD - 1);
        req = 5'b00100;
        tick(1);
        check("t6_released", 32'(gnt), 32'd0);
        check("t6_no_timeout", 32'(timeout), 32'd0);
        tick(2);
        check("t6_next", 32'(gnt_id), 32'd3);
        req = '0;
        tick(3);

        // randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) req = N_REQ'($urandom);
            if ($urandom_range(0, 149) == 0) rst = 1'b1;
            tick(1);
            rst = 1'b0;
        end
        req = '0;
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
